// File: rtl/ppu_pipe_pkg.sv
// rtl/ppu_pipe_pkg.sv - shared constants for the control-word pipeline
// Purpose : control-word field layout, default NOP word, stage index names.
// Ports   : none (package).
package ppu_pipe_pkg;

  // Packed control word produced by the CU (16 bits by default).
  localparam int CW_W       = 16;

  localparam int AM_LSB     = 0;
  localparam int AM_W       = 2;
  localparam int RF_EN_LSB  = 2;
  localparam int ALU_OP_LSB = 3;
  localparam int ALU_OP_W   = 4;
  localparam int LOAD_LSB   = 7;
  localparam int S_LSB      = 8;
  localparam int RW_LSB     = 9;
  localparam int SIZE_LSB   = 10;
  localparam int SIZE_W     = 2;
  localparam int DM_EN_LSB  = 12;

  // All enables deasserted: safe to drive into any datapath stage.
  localparam logic [CW_W-1:0] NOP_WORD_DEF = '0;

  // Default three-register chain.
  localparam int STG_IDEXE  = 0;
  localparam int STG_EXEMEM = 1;
  localparam int STG_MEMWB  = 2;

  localparam int STAGES_MAX = 8;

  function automatic logic [ALU_OP_W-1:0] get_alu_op(input logic [CW_W-1:0] w);
    return w[ALU_OP_LSB +: ALU_OP_W];
  endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// rtl/ctrl_pipe_chain_if.sv - handshake/bus bundle of the control-word pipeline
// Purpose : groups CU entry, stall/flush controls and per-stage outputs.
// Signals : in_word, in_valid, bubble, hold[STAGES], flush[STAGES]   (CU/hazard unit -> chain)
//           in_ready, stage_word[STAGES*DATA_W], stage_valid[STAGES] (chain -> CU/datapath)
// Modports: master = CU/datapath side, slave = ctrl_pipe_chain.
interface ctrl_pipe_chain_if #(
  parameter int DATA_W = 16,
  parameter int STAGES = 3
);
  logic [DATA_W-1:0]        in_word;
  logic                     in_valid;
  logic                     in_ready;
  logic                     bubble;
  logic [STAGES-1:0]        hold;
  logic [STAGES-1:0]        flush;
  logic [STAGES*DATA_W-1:0] stage_word;
  logic [STAGES-1:0]        stage_valid;

  modport master (
    output in_word, in_valid, bubble, hold, flush,
    input  in_ready, stage_word, stage_valid
  );

  modport slave (
    input  in_word, in_valid, bubble, hold, flush,
    output in_ready, stage_word, stage_valid
  );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one control-word pipeline register with valid bit
// Purpose : holds one word+valid; priority clr > ld > hold.
// Ports   : clk, reset (async, active-high), ld (load d_*), clr (load NOP/invalid),
//           d_word/d_valid (next content), q_word/q_valid (registered content).
module ctrl_pipe_stage #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_word,
  input  logic              d_valid,
  output logic [DATA_W-1:0] q_word,
  output logic              q_valid
);

  logic [DATA_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (clr) begin
      word_d  = NOP_WORD;
      valid_d = 1'b0;
    end else if (ld) begin
      word_d  = d_word;
      valid_d = d_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign q_word  = word_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - parametrised CU control-word pipeline (ID/EXE .. MEM/WB)
// Purpose : STAGES back-to-back control registers with valid bits, back-pressured
//           hold, per-stage flush and bubble insertion at entry.
// Ports   : clk, reset (async, active-high), bus (ctrl_pipe_chain_if.slave);
//           perf_bubbles[15:0], perf_stalls[15:0] only when CTRL_PIPE_PERF_EN is defined.
// Config  : CTRL_PIPE_PERF_EN adds saturating bubble/stall counters.
module ctrl_pipe_chain
  import ppu_pipe_pkg::*;
#(
  parameter int                DATA_W   = CW_W,
  parameter int                STAGES   = 3,   // 1..STAGES_MAX
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  ctrl_pipe_chain_if.slave bus
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [15:0]     perf_bubbles,
  output logic [15:0]     perf_stalls
`endif
);

  logic [STAGES-1:0]        eff_hold;
  logic [STAGES-1:0]        clr_mask;
  logic [STAGES*DATA_W-1:0] word_bus;
  logic [STAGES-1:0]        valid_bus;
  logic                     entry_valid;
  logic [DATA_W-1:0]        entry_word;

  // Suffix-OR from the oldest stage down: a hold anywhere freezes all younger
  // stages, and a flush at k clears every stage 0..k.
  always_comb begin
    eff_hold = '0;
    clr_mask = '0;
    eff_hold[STAGES-1] = bus.hold[STAGES-1];
    clr_mask[STAGES-1] = bus.flush[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      eff_hold[k] = bus.hold[k]  | eff_hold[k+1];
      clr_mask[k] = bus.flush[k] | clr_mask[k+1];
    end
  end

  // A bubble with in_valid=1 does not consume the instruction; in_ready only
  // reflects stalls, so the CU must re-present the word itself.
  assign entry_valid = bus.in_valid & ~bus.bubble;
  assign entry_word  = entry_valid ? bus.in_word : NOP_WORD;
  assign bus.in_ready = ~eff_hold[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [DATA_W-1:0] d_word;
    logic              d_valid;

    if (k == 0) begin : g_entry
      assign d_word  = entry_word;
      assign d_valid = entry_valid;
    end else begin : g_link
      // When the younger neighbour is frozen but this stage moves on, it takes
      // a bubble; copying the frozen word would duplicate it downstream.
      assign d_word  = eff_hold[k-1] ? NOP_WORD : word_bus[(k-1)*DATA_W +: DATA_W];
      assign d_valid = eff_hold[k-1] ? 1'b0     : valid_bus[k-1];
    end

    ctrl_pipe_stage #(
      .DATA_W  (DATA_W),
      .NOP_WORD(NOP_WORD)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .ld     (~eff_hold[k]),
      .clr    (clr_mask[k]),
      .d_word (d_word),
      .d_valid(d_valid),
      .q_word (word_bus[k*DATA_W +: DATA_W]),
      .q_valid(valid_bus[k])
    );
  end

  assign bus.stage_word  = word_bus;
  assign bus.stage_valid = valid_bus;

`ifdef CTRL_PIPE_PERF_EN
  logic [15:0] perf_bubbles_q, perf_bubbles_d;
  logic [15:0] perf_stalls_q,  perf_stalls_d;

  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_stalls_d  = perf_stalls_q;
    // Stage 0 loading a non-instruction counts as a bubble, whether forced or idle.
    if (~eff_hold[0] && ~entry_valid && perf_bubbles_q != 16'hFFFF)
      perf_bubbles_d = perf_bubbles_q + 16'd1;
    if (eff_hold[0] && perf_stalls_q != 16'hFFFF)
      perf_stalls_d = perf_stalls_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_bubbles_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_stalls  = perf_stalls_q;
`else
  // Counters absent: chain behaviour is unchanged.
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb/tb_ctrl_pipe_chain.sv - directed self-checking bench for ctrl_pipe_chain
module tb_ctrl_pipe_chain;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef CTRL_PIPE_PERF_EN
  logic [15:0] perf_bubbles;
  logic [15:0] perf_stalls;
`endif

  ctrl_pipe_chain_if #(.DATA_W(16), .STAGES(3)) bus ();

  ctrl_pipe_chain #(.DATA_W(16), .STAGES(3), .NOP_WORD(16'h0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .perf_bubbles(perf_bubbles),
    .perf_stalls (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] sw(input int k);
    return bus.stage_word[k*16 +: 16];
  endfunction

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] w, input logic v, input logic b,
                       input logic [2:0] h, input logic [2:0] f);
    bus.in_word  = w;
    bus.in_valid = v;
    bus.bubble   = b;
    bus.hold     = h;
    bus.flush    = f;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(16'h0, 1'b0, 1'b0, 3'b000, 3'b000);
    #12;
    checks++;
    if (bus.stage_valid !== 3'b000) begin
      errors++; $display("FAIL reset_valid got %b want %b", bus.stage_valid, 3'b000);
    end
    checks++;
    if (bus.stage_word !== 48'h0) begin
      errors++; $display("FAIL reset_word got %h want %h", bus.stage_word, 48'h0);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_fill();
    drive(16'h0A01, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    checks++;
    if (sw(0) !== 16'h0A01 || bus.stage_valid !== 3'b001) begin
      errors++; $display("FAIL fill_s0 got %h/%b want 0a01/001", sw(0), bus.stage_valid);
    end
    drive(16'h0A02, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    drive(16'h0A03, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    checks++;
    if (sw(2) !== 16'h0A01 || sw(1) !== 16'h0A02 || sw(0) !== 16'h0A03) begin
      errors++; $display("FAIL fill_words got %h %h %h want 0a01 0a02 0a03", sw(2), sw(1), sw(0));
    end
    checks++;
    if (bus.stage_valid !== 3'b111) begin
      errors++; $display("FAIL fill_valid got %b want 111", bus.stage_valid);
    end
  endtask

  task automatic test_hold();
    drive(16'h1111, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    drive(16'h2222, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    // stage0=2222 stage1=1111 stage2=0a03
    drive(16'h3333, 1'b1, 1'b0, 3'b010, 3'b000);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_ready cyc%0d got %b want 0", c, bus.in_ready);
      end
      step();
      checks++;
      if (sw(0) !== 16'h2222 || sw(1) !== 16'h1111 || bus.stage_valid[1:0] !== 2'b11) begin
        errors++; $display("FAIL hold_frozen cyc%0d got %h %h %b want 2222 1111 11", c, sw(0), sw(1), bus.stage_valid);
      end
      checks++;
      if (sw(2) !== 16'h0000 || bus.stage_valid[2] !== 1'b0) begin
        errors++; $display("FAIL hold_s2 cyc%0d got %h/%b want 0000/0", c, sw(2), bus.stage_valid[2]);
      end
    end
    drive(16'h3333, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    checks++;
    if (sw(2) !== 16'h1111 || sw(1) !== 16'h2222 || sw(0) !== 16'h3333 || bus.stage_valid !== 3'b111) begin
      errors++; $display("FAIL hold_release got %h %h %h %b want 1111 2222 3333 111", sw(2), sw(1), sw(0), bus.stage_valid);
    end
    drive(16'h0000, 1'b0, 1'b0, 3'b000, 3'b000);
    step();
    checks++;
    if (sw(2) !== 16'h2222 || sw(1) !== 16'h3333 || sw(0) !== 16'h0000 || bus.stage_valid !== 3'b110) begin
      errors++; $display("FAIL hold_drain got %h %h %h %b want 2222 3333 0000 110", sw(2), sw(1), sw(0), bus.stage_valid);
    end
  endtask

  task automatic test_flush();
    drive(16'h3001, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    drive(16'h3002, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    drive(16'h3003, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    drive(16'h3004, 1'b1, 1'b0, 3'b000, 3'b010);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready got %b want 1", bus.in_ready);
    end
    step();
    checks++;
    if (sw(2) !== 16'h3002 || sw(1) !== 16'h0000 || sw(0) !== 16'h0000 || bus.stage_valid !== 3'b100) begin
      errors++; $display("FAIL flush1 got %h %h %h %b want 3002 0000 0000 100", sw(2), sw(1), sw(0), bus.stage_valid);
    end
  endtask

  task automatic test_flush_beats_hold();
    drive(16'h4444, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    checks++;
    if (sw(0) !== 16'h4444 || bus.stage_valid[0] !== 1'b1) begin
      errors++; $display("FAIL fh_setup got %h/%b want 4444/1", sw(0), bus.stage_valid[0]);
    end
    drive(16'h4445, 1'b1, 1'b0, 3'b001, 3'b001);
    step();
    checks++;
    if (sw(0) !== 16'h0000 || bus.stage_valid[0] !== 1'b0) begin
      errors++; $display("FAIL flush_over_hold got %h/%b want 0000/0", sw(0), bus.stage_valid[0]);
    end
  endtask

  task automatic test_bubble();
    drive(16'h5555, 1'b1, 1'b1, 3'b000, 3'b000);
    step();
    checks++;
    if (sw(0) !== 16'h0000 || bus.stage_valid[0] !== 1'b0) begin
      errors++; $display("FAIL bubble_insert got %h/%b want 0000/0", sw(0), bus.stage_valid[0]);
    end
    drive(16'h5555, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    checks++;
    if (sw(0) !== 16'h5555 || bus.stage_valid[0] !== 1'b1) begin
      errors++; $display("FAIL bubble_represent got %h/%b want 5555/1", sw(0), bus.stage_valid[0]);
    end
  endtask

  task automatic test_async_reset();
    drive(16'h6666, 1'b1, 1'b0, 3'b100, 3'b000);
    step();
    checks++;
    if (sw(0) !== 16'h5555 || bus.stage_valid[0] !== 1'b1) begin
      errors++; $display("FAIL allhold_frozen got %h/%b want 5555/1", sw(0), bus.stage_valid[0]);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.stage_valid !== 3'b000 || bus.stage_word !== 48'h0) begin
      errors++; $display("FAIL async_reset got %h/%b want 0/000", bus.stage_word, bus.stage_valid);
    end
`ifdef CTRL_PIPE_PERF_EN
    checks++;
    if (perf_stalls !== 16'd0 || perf_bubbles !== 16'd0) begin
      errors++; $display("FAIL perf_reset got %0d/%0d want 0/0", perf_stalls, perf_bubbles);
    end
`endif
    #2;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (bus.stage_valid !== 3'b000 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL post_reset_hold got %b/%b want 000/0", bus.stage_valid, bus.in_ready);
    end
`ifdef CTRL_PIPE_PERF_EN
    checks++;
    if (perf_stalls !== 16'd3) begin
      errors++; $display("FAIL perf_stalls got %0d want 3", perf_stalls);
    end
    checks++;
    if (perf_bubbles !== 16'd0) begin
      errors++; $display("FAIL perf_bubbles got %0d want 0", perf_bubbles);
    end
`endif
    drive(16'h0, 1'b0, 1'b0, 3'b000, 3'b000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_hold();
    test_flush();
    test_flush_beats_hold();
    test_bubble();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
